// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared definitions for the minuteCore multi-port register file.
//   REG_DATA_SIZE / REG_ADDR_SIZE : default register width and address width
//   rf_state_e                    : init-sweep FSM state encoding (RF_INIT, RF_RUN)
package regfile_mp_pkg;

  localparam int REG_DATA_SIZE = 32;
  localparam int REG_ADDR_SIZE = 5;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_wr_arb.sv
// regfile_mp_wr_arb: write-port priority resolution for one register address.
// Reports whether any enabled write port targets addr and, if so, the data of
// the highest-index such port. Address 0 never produces a hit.
// Ports:
//   active  in   write ports are honoured only while high (RUN state)
//   addr    in   register address this instance resolves
//   wr_en   in   per-port write enables
//   wr_addr in   packed write addresses, port p at [p*ADDR_W +: ADDR_W]
//   wr_data in   packed write data, port p at [p*DATA_W +: DATA_W]
//   hit     out  some enabled port writes addr
//   data    out  winning port's data (0 when no hit)
module regfile_mp_wr_arb
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = REG_DATA_SIZE,
  parameter int ADDR_W = REG_ADDR_SIZE,
  parameter int NUM_WR = 2
) (
  input  logic                     active,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  // NOTE: combinational blocks use blocking assignments with every output
  // defaulted first, so no latch is inferred and later loop iterations
  // overwrite earlier ones -- which is exactly what gives the highest-index
  // matching port priority.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (active && (addr != '0) && wr_en[p] &&
          (wr_addr[p*ADDR_W +: ADDR_W] == addr)) begin
        hit  = 1'b1;
        data = wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with scoreboard.
// Entry 0 reads as zero. After reset an INIT sweep clears one entry per cycle
// (entries 1..2^ADDR_W-1); ready rises when the sweep is done.
// Optional feature macro: REGFILE_BYPASS_EN -- forwards same-cycle writes
// (and scoreboard sets) to reads of the same address.
// Ports:
//   clk         in   clock, all state on posedge
//   reset       in   synchronous, active-high reset
//   rd_addr     in   NUM_RD packed read addresses
//   rd_data     out  NUM_RD packed registered read data
//   rd_busy     out  registered scoreboard bit per read port
//   wr_en       in   NUM_WR write enables (higher index wins on collision)
//   wr_addr     in   NUM_WR packed write addresses
//   wr_data     in   NUM_WR packed write data
//   sb_set_en   in   mark sb_set_addr pending
//   sb_set_addr in   destination being issued
//   ready       out  init sweep complete
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = REG_DATA_SIZE,
  parameter int ADDR_W = REG_ADDR_SIZE,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;

  rf_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                run;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    busy_q;

  logic [DEPTH-1:0]    ent_we;
  logic [DATA_W-1:0]   ent_wdata [DEPTH];

  logic [ADDR_W-1:0]   rd_a [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_d, rd_data_q;
  logic [NUM_RD-1:0]        rd_busy_d, rd_busy_q;

  assign run = (state_q == RF_RUN);

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RF_INIT;
      cnt_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) state_d = RF_RUN;
      end
      RF_RUN:  state_d = RF_RUN;
      default: state_d = RF_INIT;
    endcase
  end

  // ---------------------------------------------- per-entry write resolution
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    regfile_mp_wr_arb #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_arb (
      .active  (run),
      .addr    (ADDR_W'(i)),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit     (ent_we[i]),
      .data    (ent_wdata[i])
    );
  end

  // ---------------------------------------------------------------- storage
  // NOTE: the array has no reset term; the INIT sweep clears it one entry
  // per cycle, which keeps it mappable onto RAM-style storage. Entry 0 is
  // never written; the read mux forces it to zero.
  always_ff @(posedge clk) begin
    if (state_q == RF_INIT) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (ent_we[i]) mem[i] <= ent_wdata[i];
      end
    end
  end

  // ------------------------------------------------------------- scoreboard
  // A writeback clears busy; an issue in the same cycle sets it again because
  // a newer producer now owns the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else if (run) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (ent_we[i]) busy_q[i] <= 1'b0;
        if (sb_set_en && (sb_set_addr == ADDR_W'(i))) busy_q[i] <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------ reads
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign rd_a[k] = rd_addr[k*ADDR_W +: ADDR_W];
  end

  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    if (run) begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (rd_a[k] != '0) begin
          rd_data_d[k*DATA_W +: DATA_W] = mem[rd_a[k]];
          rd_busy_d[k]                  = busy_q[rd_a[k]];
`ifdef REGFILE_BYPASS_EN
          // Forward the winning same-cycle write and the post-update busy bit.
          if (ent_we[rd_a[k]]) begin
            rd_data_d[k*DATA_W +: DATA_W] = ent_wdata[rd_a[k]];
            rd_busy_d[k] = sb_set_en && (sb_set_addr == rd_a[k]);
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;
  assign ready   = run;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp with a behavioural
// register-file model (plain arrays, one update per clock).
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int SWEEP = DEPTH - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              sb_set_en;
  logic [AW-1:0]     sb_set_addr;
  logic              ready;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];
  int            m_init_left;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    sb_set_en = 1'b0;
    sb_set_addr = '0;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_sb(input int a);
    sb_set_en   = 1'b1;
    sb_set_addr = AW'(a);
  endtask

  // One clock: predict from the model using the inputs currently driven,
  // advance the model, then compare all outputs shortly after the edge.
  task automatic cycle();
    logic [DW-1:0] e_data [NR];
    bit            e_busy [NR];
    bit            e_ready;
    int            a;
    for (int k = 0; k < NR; k++) begin
      e_data[k] = '0;
      e_busy[k] = 1'b0;
    end
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_init_left = SWEEP;
      e_ready = 1'b0;
    end else if (m_init_left > 0) begin
      m_init_left--;
      e_ready = (m_init_left == 0);
    end else begin
      for (int k = 0; k < NR; k++) begin
        a = int'(rd_addr[k*AW +: AW]);
        if (a != 0) begin
          e_data[k] = m_mem[a];
          e_busy[k] = m_busy[a];
        end
      end
      // Apply writes in ascending port order: the last one to land wins.
      for (int p = 0; p < NW; p++) begin
        a = int'(wr_addr[p*AW +: AW]);
        if (wr_en[p] && a != 0) begin
          m_mem[a]  = wr_data[p*DW +: DW];
          m_busy[a] = 1'b0;
        end
      end
      if (sb_set_en && sb_set_addr != '0) m_busy[int'(sb_set_addr)] = 1'b1;
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NR; k++) begin
        a = int'(rd_addr[k*AW +: AW]);
        for (int p = 0; p < NW; p++) begin
          if (a != 0 && wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) begin
            e_data[k] = m_mem[a];
            e_busy[k] = m_busy[a];
          end
        end
      end
`endif
      e_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("ready", 64'(ready), 64'(e_ready));
    for (int k = 0; k < NR; k++) begin
      check($sformatf("rd_data%0d", k), 64'(rd_data[k*DW +: DW]), 64'(e_data[k]));
      check($sformatf("rd_busy%0d", k), 64'(rd_busy[k]), 64'(e_busy[k]));
    end
  endtask

  initial begin
    reset   = 1'b1;
    rd_addr = '0;
    idle();
    m_init_left = SWEEP;

    // Reset held one cycle, then the 31-cycle sweep.
    cycle();
    reset = 1'b0;
    set_rd(0, 7);
    for (int i = 0; i < SWEEP - 1; i++) cycle();
    check("ready_low_before_sweep_end", 64'(ready), 64'(0));
    cycle();
    check("ready_after_sweep", 64'(ready), 64'(1));
    cycle();
    check("r7_after_init", 64'(rd_data[0 +: DW]), 64'(0));
    check("r7_busy_after_init", 64'(rd_busy[0]), 64'(0));

    // Write then read one cycle later.
    set_wr(0, 5, 32'hDEADBEEF);
    cycle();
    idle();
    set_rd(0, 5);
    cycle();
    check("r5_readback", 64'(rd_data[0 +: DW]), 64'(32'hDEADBEEF));

    // Same-address collision: port 1 wins.
    set_wr(0, 9, 32'h11);
    set_wr(1, 9, 32'h22);
    cycle();
    idle();
    set_rd(1, 9);
    cycle();
    check("r9_collision", 64'(rd_data[DW +: DW]), 64'(32'h22));

    // Register 0 is constant zero and never busy.
    set_wr(0, 0, 32'hFFFFFFFF);
    cycle();
    idle();
    set_rd(0, 0);
    cycle();
    check("r0_data", 64'(rd_data[0 +: DW]), 64'(0));
    set_sb(0);
    cycle();
    idle();
    cycle();
    check("r0_busy", 64'(rd_busy[0]), 64'(0));

    // Scoreboard set / set-wins-over-write / write clears.
    set_sb(3);
    cycle();
    idle();
    set_rd(0, 3);
    cycle();
    check("r3_busy_set", 64'(rd_busy[0]), 64'(1));
    set_wr(1, 3, 32'h33);
    set_sb(3);
    cycle();
    idle();
    cycle();
    check("r3_busy_set_wins", 64'(rd_busy[0]), 64'(1));
    set_wr(0, 3, 32'h44);
    cycle();
    idle();
    cycle();
    check("r3_busy_cleared", 64'(rd_busy[0]), 64'(0));
    check("r3_data", 64'(rd_data[0 +: DW]), 64'(32'h44));

    // Same-cycle write and read of r4 (previously zero).
    set_wr(0, 4, 32'hA5);
    set_rd(1, 4);
    cycle();
`ifdef REGFILE_BYPASS_EN
    check("r4_same_cycle", 64'(rd_data[DW +: DW]), 64'(32'hA5));
`else
    check("r4_same_cycle", 64'(rd_data[DW +: DW]), 64'(0));
`endif
    idle();
    cycle();
    check("r4_next_cycle", 64'(rd_data[DW +: DW]), 64'(32'hA5));

    // Randomised traffic, addresses mostly in a small window to force collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int k = 0; k < NR; k++)
        set_rd(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 7));
      for (int p = 0; p < NW; p++)
        if ($urandom_range(0, 1) == 1) set_wr(p, $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 2) == 0) set_sb($urandom_range(0, 7));
      cycle();
    end
    idle();

    // Reset mid-sweep at cnt=12: the sweep restarts from the beginning.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 11; i++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < SWEEP - 1; i++) cycle();
    check("ready_low_after_midsweep_reset", 64'(ready), 64'(0));
    cycle();
    check("ready_after_midsweep_reset", 64'(ready), 64'(1));
    set_rd(0, 5);
    set_rd(1, 3);
    cycle();
    check("r5_cleared_by_sweep", 64'(rd_data[0 +: DW]), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
